// File: rtl/wb_trace_fifo.sv
// Write-back trace FIFO: captures register-file writes into a first-word-fall-through queue.
// Optional WB_TRACE_TS_EN adds a free-running cycle timestamp per entry and an rd_ts port.
module wb_trace_fifo #(
  parameter int unsigned DEPTH   = 16,
  parameter bit          SKIP_R0 = 1'b1,
  parameter int unsigned DROP_W  = 16
) (
  input  logic                     clk_CPU,
  input  logic                     rst_CPU,
  input  logic                     regWrite_in,
  input  logic [4:0]               wAddr_in,
  input  logic [31:0]              wrData_in,
  input  logic                     rd_ready,
  output logic                     rd_valid,
  output logic [4:0]               rd_addr,
  output logic [31:0]              rd_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty,
  output logic                     overflow,
  output logic [DROP_W-1:0]        drop_cnt
`ifdef WB_TRACE_TS_EN
  ,
  output logic [31:0]              rd_ts
`endif
);

  localparam int unsigned AW = $clog2(DEPTH);
`ifdef WB_TRACE_TS_EN
  localparam int unsigned EW = 32 + 5 + 32;
`else
  localparam int unsigned EW = 5 + 32;
`endif

  logic [EW-1:0]     mem [DEPTH];
  logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [AW:0]       count_q, count_d;
  logic              overflow_q;
  logic [DROP_W-1:0] drop_cnt_q;
  logic [EW-1:0]     wr_entry, head;
  logic              push_req, pop, push_ok, drop;

`ifdef WB_TRACE_TS_EN
  logic [31:0] ts_q;

  always_ff @(posedge clk_CPU) begin
    if (rst_CPU) ts_q <= '0;
    else         ts_q <= ts_q + 32'd1;
  end

  assign wr_entry = {ts_q, wAddr_in, wrData_in};
  assign rd_ts    = empty ? 32'd0 : head[68:37];
`else
  assign wr_entry = {wAddr_in, wrData_in};
`endif

  assign head     = mem[rd_ptr_q];
  assign empty    = (count_q == '0);
  assign full     = (count_q == (AW+1)'(DEPTH));
  assign count    = count_q;
  assign rd_valid = !empty;
  assign rd_addr  = empty ? 5'd0 : head[36:32];
  assign rd_data  = empty ? 32'd0 : head[31:0];
  assign overflow = overflow_q;
  assign drop_cnt = drop_cnt_q;

  // A pop in the same cycle frees the slot, so a full FIFO can still accept.
  always_comb begin
    push_req = regWrite_in && !(SKIP_R0 && (wAddr_in == 5'd0));
    pop      = rd_valid && rd_ready;
    push_ok  = push_req && (!full || pop);
    drop     = push_req && full && !pop;
    count_d  = count_q;
    if (push_ok && !pop)      count_d = count_q + 1'b1;
    else if (!push_ok && pop) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk_CPU) begin
    if (push_ok && !rst_CPU) mem[wr_ptr_q] <= wr_entry;
  end

  always_ff @(posedge clk_CPU) begin
    if (rst_CPU) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      count_q <= count_d;
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)     rd_ptr_q <= rd_ptr_q + 1'b1;
      if (drop) begin
        overflow_q <= 1'b1;
        if (drop_cnt_q != {DROP_W{1'b1}}) drop_cnt_q <= drop_cnt_q + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_wb_trace_fifo.sv
// Scoreboard bench for wb_trace_fifo: queue-level reference model plus decoupled monitor.
module tb_wb_trace_fifo;

  localparam int DEPTH = 16;

  typedef struct {
    logic [4:0]  a;
    logic [31:0] d;
    logic [31:0] ts;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rw = 1'b0;
  logic [4:0]  wa = '0;
  logic [31:0] wd = '0;
  logic        rdy = 1'b0;

  logic        rd_valid, full, empty, overflow;
  logic [4:0]  rd_addr;
  logic [31:0] rd_data, rd_ts;
  logic [4:0]  count;
  logic [15:0] drop_cnt;

  logic        rst2 = 1'b1;
  logic        rd_valid2, full2, empty2, overflow2;
  logic [4:0]  rd_addr2, count2;
  logic [31:0] rd_data2, rd_ts2;
  logic [15:0] drop_cnt2;

  int checks = 0;
  int passes = 0;

  // reference model state
  ent_t        sb[$];
  int          m_count = 0;
  bit          m_over = 0;
  int          m_drop = 0;
  logic [31:0] m_ts = '0;
  bit          armed = 0;

  always #5 clk = ~clk;

  wb_trace_fifo #(.DEPTH(DEPTH), .SKIP_R0(1'b1), .DROP_W(16)) dut (
    .clk_CPU(clk), .rst_CPU(rst), .regWrite_in(rw), .wAddr_in(wa), .wrData_in(wd),
    .rd_ready(rdy), .rd_valid(rd_valid), .rd_addr(rd_addr), .rd_data(rd_data),
    .count(count), .full(full), .empty(empty), .overflow(overflow), .drop_cnt(drop_cnt)
`ifdef WB_TRACE_TS_EN
    , .rd_ts(rd_ts)
`endif
  );

  wb_trace_fifo #(.DEPTH(DEPTH), .SKIP_R0(1'b0), .DROP_W(16)) dut_r0 (
    .clk_CPU(clk), .rst_CPU(rst2), .regWrite_in(rw), .wAddr_in(wa), .wrData_in(wd),
    .rd_ready(1'b0), .rd_valid(rd_valid2), .rd_addr(rd_addr2), .rd_data(rd_data2),
    .count(count2), .full(full2), .empty(empty2), .overflow(overflow2), .drop_cnt(drop_cnt2)
`ifdef WB_TRACE_TS_EN
    , .rd_ts(rd_ts2)
`endif
  );

`ifndef WB_TRACE_TS_EN
  assign rd_ts  = '0;
  assign rd_ts2 = '0;
`endif

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("FAIL %s got %0h expected %0h at %0t", name, got, exp, $time);
  endtask

  // Model: queue of accepted entries, occupancy as a plain integer.
  always @(posedge clk) begin
    bit pop_m, push_m;
    if (rst) begin
      m_count = 0;
      m_over  = 0;
      m_drop  = 0;
      m_ts    = '0;
      sb.delete();
      armed   = 1;
    end else begin
      pop_m  = (m_count > 0) && rdy;
      push_m = rw && (wa != 5'd0);
      if (push_m) begin
        if (m_count < DEPTH || pop_m) begin
          sb.push_back('{a: wa, d: wd, ts: m_ts});
          m_count++;
        end else begin
          m_over = 1;
          if (m_drop < 65535) m_drop++;
        end
      end
      if (pop_m) m_count--;
      m_ts = m_ts + 32'd1;
    end
  end

  // Monitor: flag/count checks every cycle, head compared at each handshake.
  always @(negedge clk) begin
    ent_t e;
    if (armed) begin
      chk("count", 64'(count), 64'(m_count));
      chk("empty", 64'(empty), 64'(m_count == 0));
      chk("full", 64'(full), 64'(m_count == DEPTH));
      chk("rd_valid", 64'(rd_valid), 64'(m_count != 0));
      chk("overflow", 64'(overflow), 64'(m_over));
      chk("drop_cnt", 64'(drop_cnt), 64'(m_drop));
      if (m_count == 0) begin
        chk("empty_addr", 64'(rd_addr), 64'd0);
        chk("empty_data", 64'(rd_data), 64'd0);
`ifdef WB_TRACE_TS_EN
        chk("empty_ts", 64'(rd_ts), 64'd0);
`endif
      end
      if (!rst && rd_valid && rdy) begin
        if (sb.size() == 0) begin
          chk("sb_underflow", 64'd1, 64'd0);
        end else begin
          e = sb.pop_front();
          chk("head_addr", 64'(rd_addr), 64'(e.a));
          chk("head_data", 64'(rd_data), 64'(e.d));
`ifdef WB_TRACE_TS_EN
          chk("head_ts", 64'(rd_ts), 64'(e.ts));
`endif
        end
      end
    end
  end

  task automatic drive(input logic w, input logic [4:0] a, input logic [31:0] d,
                       input logic r);
    @(posedge clk);
    #1;
    rw  = w;
    wa  = a;
    wd  = d;
    rdy = r;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 5'd0, 32'd0, 1'b0);
  endtask

  initial begin
    int pct;
    // reset then idle
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
    idle(3);

    // single capture, then drain it
    drive(1'b1, 5'd5, 32'h0000_002A, 1'b0);
    idle(2);
    drive(1'b0, 5'd0, 32'd0, 1'b1);
    idle(2);

    // R0 filter on both instances
    rst2 = 1'b1;
    idle(1);
    rst2 = 1'b0;
    drive(1'b1, 5'd0, 32'hDEAD_BEEF, 1'b0);
    idle(1);
    @(negedge clk);
    chk("r0_count", 64'(count2), 64'd1);
    chk("r0_data", 64'(rd_data2), 64'hDEAD_BEEF);
    chk("r0_valid", 64'(rd_valid2), 64'd1);
    rst2 = 1'b1;
    idle(1);

    // fill past capacity, then drain
    for (int i = 1; i <= 18; i++) drive(1'b1, 5'(i % 31 + 1), 32'(i), 1'b0);
    idle(2);
    for (int i = 0; i < 20; i++) drive(1'b0, 5'd0, 32'd0, 1'b1);
    idle(2);

    // full with simultaneous push and pop
    for (int i = 1; i <= 16; i++) drive(1'b1, 5'd7, 32'(i), 1'b0);
    idle(1);
    drive(1'b1, 5'd9, 32'h99, 1'b1);
    idle(1);
    for (int i = 0; i < 20; i++) drive(1'b0, 5'd0, 32'd0, 1'b1);

    // back-to-back push/pop across pointer wrap
    for (int i = 0; i < 40; i++) drive(1'b1, 5'(i % 31 + 1), 32'h100 + 32'(i), 1'b1);
    idle(2);

    // reset mid-drain
    for (int i = 0; i < 3; i++) drive(1'b1, 5'd3, 32'h200 + 32'(i), 1'b0);
    drive(1'b0, 5'd0, 32'd0, 1'b1);
    rst = 1'b1;
    drive(1'b0, 5'd0, 32'd0, 1'b1);
    rst = 1'b0;
    idle(2);

    // randomized traffic at several drain rates
    for (int p = 0; p < 3; p++) begin
      pct = (p == 0) ? 20 : (p == 1) ? 50 : 90;
      for (int i = 0; i < 200; i++)
        drive(($urandom_range(0, 3) != 0), 5'($urandom_range(0, 31)), $urandom,
              ($urandom_range(0, 99) < pct));
    end
    for (int i = 0; i < 25; i++) drive(1'b0, 5'd0, 32'd0, 1'b1);
    idle(2);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
